// File: rtl/gap_feeder_if.sv
// rtl/gap_feeder_if.sv - pixel-in / beat-out bus between a pixel source and gap_feeder
//
// Signals:
//   i_start    source -> feeder  one-cycle pulse arming a new feature map
//   i_valid    source -> feeder  pixel valid
//   i_data     source -> feeder  pixel value (DW bits, unsigned)
//   o_ready    feeder -> source  pixel accepted on an edge where i_valid && o_ready
//   o_writeAdd feeder -> sink    one-cycle beat qualifier
//   o_data     feeder -> sink    packed beat, first pixel in the top lane
//   o_done     feeder -> sink    map complete, held until the next accepted i_start
interface gap_feeder_if #(
  parameter int LANES = 9,
  parameter int DW    = 10
) ();
  logic                  i_start;
  logic                  i_valid;
  logic [DW-1:0]         i_data;
  logic                  o_ready;
  logic                  o_writeAdd;
  logic [LANES*DW-1:0]   o_data;
  logic                  o_done;

  modport master (
    output i_start, i_valid, i_data,
    input  o_ready, o_writeAdd, o_data, o_done
  );

  modport slave (
    input  i_start, i_valid, i_data,
    output o_ready, o_writeAdd, o_data, o_done
  );
endinterface

// File: rtl/gap_feeder.sv
// rtl/gap_feeder.sv - packs a serial pixel stream into LANES-wide beats for global average pooling
//
// Ports:
//   i_clk    clock, all state changes on the rising edge
//   i_reset  asynchronous active-low reset
//   bus      gap_feeder_if.slave (i_start/i_valid/i_data in, o_ready/o_writeAdd/o_data/o_done out)
//
// Pixels of one map are accepted at full rate while in FILL. The first pixel of
// each beat lands in the most significant lane. A beat is emitted on the cycle
// after its last lane fills, or after the final pixel of the map, in which case
// the unfilled lanes are zero.
module gap_feeder #(
  parameter int N_PIX = 4096,
  parameter int LANES = 9,
  parameter int DW    = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  gap_feeder_if.slave bus
);

  localparam int PCW = $clog2(N_PIX + 1);
  localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BW  = LANES * DW;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t           state_q, state_n;
  logic [PCW-1:0]   pix_cnt;
  logic [LCW-1:0]   lane_cnt;
  logic [BW-1:0]    pack_q;
  logic [BW-1:0]    pack_ins;
  logic [BW-1:0]    data_q;
  logic             ready_q;
  logic             wadd_q;
  logic             done_q;

  logic accept;
  logic last_pix;
  logic beat_end;
  logic start_ok;

  assign accept   = bus.i_valid && ready_q;
  assign last_pix = (pix_cnt == PCW'(N_PIX - 1));
  assign beat_end = (lane_cnt == LCW'(LANES - 1));
  assign start_ok = bus.i_start && (state_q == IDLE || state_q == DONE);

  // Current pack with the incoming pixel dropped into its lane; lane 0 is the top slice.
  always_comb begin
    pack_ins = pack_q;
    for (int l = 0; l < LANES; l++) begin
      if (lane_cnt == LCW'(l)) begin
        pack_ins[(LANES - l) * DW - 1 -: DW] = bus.i_data;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (bus.i_start)       state_n = FILL;
      FILL:    if (accept && last_pix) state_n = DONE;
      DONE:    if (bus.i_start)       state_n = FILL;
      default:                        state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ready_q  <= 1'b0;
      wadd_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      pack_q   <= '0;
      pix_cnt  <= '0;
      lane_cnt <= '0;
    end else begin
      // Ready is a registered copy of "next state is FILL", so it is high exactly in FILL.
      ready_q <= (state_n == FILL);
      wadd_q  <= 1'b0;
      if (start_ok) begin
        done_q <= 1'b0;
      end
      if (accept) begin
        // The output register frees the pack immediately, so filling never stalls.
        if (beat_end || last_pix) begin
          data_q <= pack_ins;
          wadd_q <= 1'b1;
          pack_q <= '0;
        end else begin
          pack_q <= pack_ins;
        end
        if (last_pix) begin
          lane_cnt <= '0;
          pix_cnt  <= '0;
          done_q   <= 1'b1;
        end else begin
          lane_cnt <= beat_end ? '0 : lane_cnt + LCW'(1);
          pix_cnt  <= pix_cnt + PCW'(1);
        end
      end
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_writeAdd = wadd_q;
  assign bus.o_data     = data_q;
  assign bus.o_done     = done_q;

endmodule

// File: tb/tb_gap_feeder.sv
// tb/tb_gap_feeder.sv - directed self-checking bench for gap_feeder
module tb_gap_feeder;
  localparam int N  = 4096;
  localparam int L  = 9;
  localparam int W  = 10;
  localparam int NB = (N + L - 1) / L;
  localparam int NS = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gap_feeder_if #(.LANES(L), .DW(W)) bus ();
  gap_feeder_if #(.LANES(L), .DW(W)) sbus ();

  gap_feeder #(.N_PIX(N), .LANES(L), .DW(W)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  gap_feeder #(.N_PIX(NS), .LANES(L), .DW(W)) dut_s (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (sbus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [L*W-1:0] got, input logic [L*W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pix_val(input int mode, input int idx);
    logic [W-1:0] v;
    case (mode)
      0:       v = W'(8);
      1:       v = (idx % 9 == 0) ? W'(255) : W'(200);
      default: v = W'(idx % 1024);
    endcase
    return v;
  endfunction

  function automatic logic [L*W-1:0] exp_beat(input int mode, input int b);
    logic [L*W-1:0] e;
    e = '0;
    for (int k = 0; k < L; k++) begin
      if (b * L + k < N) e[(L - k) * W - 1 -: W] = pix_val(mode, b * L + k);
    end
    return e;
  endfunction

  // Arms a map from IDLE/DONE; optionally presents a pixel alongside the start pulse.
  task automatic start_map(input bit with_valid, input string tag);
    bus.i_start = 1'b1;
    bus.i_valid = with_valid;
    bus.i_data  = '1;
    chk($sformatf("%s_ready_low_on_start", tag), L*W'(bus.o_ready), '0);
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    chk($sformatf("%s_ready_after_start", tag), L*W'(bus.o_ready), L*W'(1));
    chk($sformatf("%s_done_cleared", tag), L*W'(bus.o_done), '0);
  endtask

  task automatic run_map(input int mode, input int duty, input int start_at, input int abort_at,
                         input string tag, input longint exp_sum);
    int pix, beats, mism, early_done, stalls, cyc, bad_b;
    longint sum;
    bit fin, done_last, aborted, v;
    logic [L*W-1:0] bad_got, bad_exp;
    pix = 0; beats = 0; mism = 0; early_done = 0; stalls = 0; cyc = 0; bad_b = -1;
    sum = 0; fin = 0; done_last = 0; aborted = 0;
    bad_got = '0; bad_exp = '0;
    while (cyc < 20000) begin
      if (bus.o_writeAdd) begin
        if (bus.o_data !== exp_beat(mode, beats)) begin
          mism++;
          if (bad_b < 0) begin bad_b = beats; bad_got = bus.o_data; bad_exp = exp_beat(mode, beats); end
        end
        for (int k = 0; k < L; k++) sum += longint'(bus.o_data[(L - k) * W - 1 -: W]);
        beats++;
        if (bus.o_done) begin fin = 1; done_last = (beats == NB); end
      end else if (bus.o_done) begin
        early_done++;
      end
      if (fin) break;
      if (abort_at > 0 && pix == abort_at) begin aborted = 1; break; end
      if (pix < N && bus.o_ready !== 1'b1) stalls++;
      bus.i_start = (pix == start_at);
      v = (duty >= 100) || ($urandom_range(99) < duty);
      if (pix < N) begin
        bus.i_valid = v;
        bus.i_data  = pix_val(mode, pix);
        if (v && bus.o_ready) pix++;
      end else begin
        bus.i_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.i_valid = 1'b0;
    bus.i_start = 1'b0;
    if (!aborted) begin
      chk($sformatf("%s_finished", tag), L*W'(fin), L*W'(1));
      chk($sformatf("%s_pixels", tag), L*W'(pix), L*W'(N));
      chk($sformatf("%s_beats", tag), L*W'(beats), L*W'(NB));
      if (mism != 0) $display("  %s first bad beat %0d got=%0h exp=%0h", tag, bad_b, bad_got, bad_exp);
      chk($sformatf("%s_bad_beats", tag), L*W'(mism), '0);
      chk($sformatf("%s_done_with_last", tag), L*W'(done_last), L*W'(1));
      chk($sformatf("%s_early_done", tag), L*W'(early_done), '0);
      chk($sformatf("%s_stalls", tag), L*W'(stalls), '0);
      chk($sformatf("%s_lane_sum", tag), L*W'(sum), L*W'(exp_sum));
    end
  endtask

  initial begin
    int idle_wadd, idle_notdone, idle_ready, spix, sbeats;
    logic [L*W-1:0] sexp0, sexp1;

    bus.i_start = 1'b0; bus.i_valid = 1'b0; bus.i_data = '0;
    sbus.i_start = 1'b0; sbus.i_valid = 1'b0; sbus.i_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", L*W'(bus.o_ready), '0);
    chk("rst_wadd", L*W'(bus.o_writeAdd), '0);
    chk("rst_data", bus.o_data, '0);
    chk("rst_done", L*W'(bus.o_done), '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", L*W'(bus.o_ready), '0);

    // Map of constant 8s at full rate: average of all lanes over N is 8.
    start_map(1'b0, "all8");
    run_map(0, 100, -1, -1, "all8", 64'd32768);
    chk("all8_last_beat", bus.o_data, {10'd8, 80'd0});

    idle_wadd = 0; idle_notdone = 0; idle_ready = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.o_writeAdd) idle_wadd++;
      if (!bus.o_done) idle_notdone++;
      if (bus.o_ready) idle_ready++;
    end
    chk("done_no_beats", L*W'(idle_wadd), '0);
    chk("done_held", L*W'(idle_notdone), '0);
    chk("done_ready_low", L*W'(idle_ready), '0);
    chk("done_data_held", bus.o_data, {10'd8, 80'd0});

    // Start with a pixel in DONE (pixel must be dropped), and a stray start in FILL.
    start_map(1'b1, "pattern");
    run_map(1, 100, 500, -1, "pattern", 64'd844280);
    chk("pattern_last_beat", bus.o_data, {10'd255, 80'd0});

    start_map(1'b0, "gaps");
    run_map(2, 60, -1, -1, "gaps", 64'd2095104);

    // Abort after pixel 100, reset asynchronously mid-cycle.
    start_map(1'b0, "abort");
    run_map(2, 100, -1, 101, "abort", 64'd0);
    chk("pre_reset_data_nonzero", L*W'(bus.o_data != '0), L*W'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", L*W'(bus.o_ready), '0);
    chk("async_rst_wadd", L*W'(bus.o_writeAdd), '0);
    chk("async_rst_data", bus.o_data, '0);
    chk("async_rst_done", L*W'(bus.o_done), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_map(1'b0, "after_reset");
    run_map(2, 100, -1, -1, "after_reset", 64'd2095104);

    // Small build: 18 pixels give two full beats and no padded beat.
    sexp0 = '0; sexp1 = '0;
    for (int k = 0; k < L; k++) begin
      sexp0[(L - k) * W - 1 -: W] = W'(k + 1);
      sexp1[(L - k) * W - 1 -: W] = W'(k + 10);
    end
    sbus.i_start = 1'b1;
    @(negedge clk);
    sbus.i_start = 1'b0;
    spix = 0; sbeats = 0;
    for (int c = 0; c < 40; c++) begin
      if (sbus.o_writeAdd) begin
        if (sbeats == 0) begin
          chk("small_beat0", sbus.o_data, sexp0);
          chk("small_beat0_done", L*W'(sbus.o_done), '0);
        end else if (sbeats == 1) begin
          chk("small_beat1", sbus.o_data, sexp1);
          chk("small_beat1_done", L*W'(sbus.o_done), L*W'(1));
        end
        sbeats++;
      end
      if (spix < NS) begin
        sbus.i_valid = 1'b1;
        sbus.i_data  = W'(spix + 1);
        if (sbus.o_ready) spix++;
      end else begin
        sbus.i_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("small_beats", L*W'(sbeats), L*W'(2));
    chk("small_done_held", L*W'(sbus.o_done), L*W'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
